temp_scan_scheduler: RTL and testbench

//   Periodic round-robin scheduler for N temperature sensors sharing one threshold comparator.

---
 rtl/temp_pkg.sv | 20 ++
 rtl/temp_threshold_cmp.sv | 17 +
 rtl/temp_scan_scheduler.sv | 179 +++++++++++++++++
 tb/tb_temp_scan_scheduler.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_pkg.sv
// temp_pkg: shared state and direction types for the temperature
// scan scheduler and its threshold comparator.
package temp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TICK,
      REQUEST,
      EVALUATE
   } scanState_t;

   typedef enum logic {
      DIR_LOW,
      DIR_HIGH
   } dir_t;

   localparam logic [7:0] DEF_LOW_TH  = 8'd35;
   localparam logic [7:0] DEF_HIGH_TH = 8'd39;

endpackage

// File: rtl/temp_threshold_cmp.sv
// temp_threshold_cmp: unsigned 8-bit window compare, shared by all
// sensors. Readings equal to either limit count as normal.
module temp_threshold_cmp
   import temp_pkg::*;
#(
   parameter logic [7:0] LOW_TH  = DEF_LOW_TH,
   parameter logic [7:0] HIGH_TH = DEF_HIGH_TH
) (
   input  logic [7:0] data,
   output logic       isLow,
   output logic       isHigh
);

   assign isLow  = data < LOW_TH;
   assign isHigh = data > HIGH_TH;

endmodule

// File: rtl/temp_scan_scheduler.sv
// temp_scan_scheduler: periodic round-robin scan of N sensors with
// per-sensor debounce, latched alarms and request timeout faults.
module temp_scan_scheduler
   import temp_pkg::*;
#(
   parameter int         N_SENSORS  = 4,
   parameter logic [7:0] LOW_TH     = DEF_LOW_TH,
   parameter logic [7:0] HIGH_TH    = DEF_HIGH_TH,
   parameter int         DEBOUNCE   = 3,
   parameter int         SAMPLE_DIV = 16,
   parameter int         TIMEOUT    = 15,
   localparam int        SEL_W      = $clog2(N_SENSORS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   output logic                 sensor_req,
   output logic [SEL_W-1:0]     sensor_sel,
   input  logic                 sensor_valid,
   input  logic [7:0]           sensor_data,
   output logic [N_SENSORS-1:0] alarm_low,
   output logic [N_SENSORS-1:0] alarm_high,
   output logic                 alarm_irq,
   input  logic                 alarm_ack,
   output logic [N_SENSORS-1:0] sensor_fault,
   output logic                 scan_done,
   output logic                 busy
);

   localparam int TICK_W = $clog2(SAMPLE_DIV);
   localparam int TO_W   = $clog2(TIMEOUT + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_SENSORS - 1);
   localparam logic [2:0]        DB_MAX    = 3'(DEBOUNCE);

   scanState_t        state;
   logic [TICK_W-1:0] tick;
   logic [TO_W-1:0]   toCnt;
   logic [SEL_W-1:0]  sel;
   logic [7:0]        sample;
   logic [2:0]        dbCnt [N_SENSORS];
   dir_t              dbDir [N_SENSORS];

   logic       isLow;
   logic       isHigh;
   logic [2:0] curCnt;
   logic [2:0] nxtCnt;
   dir_t       curDir;
   dir_t       newDir;
   dir_t       nxtDir;
   logic       timedOut;
   logic       advance;
   logic [N_SENSORS-1:0] setLow;
   logic [N_SENSORS-1:0] setHigh;

   temp_threshold_cmp #(
      .LOW_TH (LOW_TH),
      .HIGH_TH(HIGH_TH)
   ) uCmp (
      .data  (sample),
      .isLow (isLow),
      .isHigh(isHigh)
   );

   always_comb begin
      curCnt  = dbCnt[sel];
      curDir  = dbDir[sel];
      newDir  = isHigh ? DIR_HIGH : DIR_LOW;
      nxtCnt  = '0;
      nxtDir  = curDir;
      setLow  = '0;
      setHigh = '0;
      if (isLow || isHigh) begin
         nxtDir = newDir;
         if (curCnt != 3'd0 && curDir == newDir)
            nxtCnt = (curCnt == DB_MAX) ? DB_MAX : curCnt + 3'd1;
         else
            nxtCnt = 3'd1;
      end
      // A saturated counter keeps re-asserting, so ack cannot hide it
      if (enable && state == EVALUATE && nxtCnt == DB_MAX) begin
         if (nxtDir == DIR_LOW) setLow[sel] = 1'b1;
         else                   setHigh[sel] = 1'b1;
      end
   end

   assign timedOut = state == REQUEST && !sensor_valid
                     && toCnt == TO_LAST;
   assign advance  = state == EVALUATE || timedOut;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         tick         <= '0;
         toCnt        <= '0;
         sel          <= '0;
         sample       <= '0;
         sensor_req   <= 1'b0;
         sensor_sel   <= '0;
         sensor_fault <= '0;
         scan_done    <= 1'b0;
         for (int i = 0; i < N_SENSORS; i++) begin
            dbCnt[i] <= '0;
            dbDir[i] <= DIR_LOW;
         end
      end else begin
         scan_done <= 1'b0;
         if (!enable) begin
            state      <= IDLE;
            sensor_req <= 1'b0;
            tick       <= '0;
         end else begin
            // Free-running tick keeps the scan period fixed
            if (state != IDLE)
               tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
            unique case (state)
               IDLE: begin
                  state <= WAIT_TICK;
                  tick  <= '0;
               end
               WAIT_TICK: begin
                  if (tick == TICK_LAST) begin
                     state      <= REQUEST;
                     sel        <= '0;
                     sensor_sel <= '0;
                     sensor_req <= 1'b1;
                     toCnt      <= '0;
                  end
               end
               REQUEST: begin
                  if (sensor_valid) begin
                     sample     <= sensor_data;
                     sensor_req <= 1'b0;
                     state      <= EVALUATE;
                  end else if (timedOut) begin
                     sensor_fault[sel] <= 1'b1;
                  end else begin
                     toCnt <= toCnt + 1'b1;
                  end
               end
               EVALUATE: begin
                  sensor_fault[sel] <= 1'b0;
                  dbCnt[sel]        <= nxtCnt;
                  dbDir[sel]        <= nxtDir;
               end
            endcase
            if (advance) begin
               if (sel == SEL_LAST) begin
                  scan_done  <= 1'b1;
                  sensor_req <= 1'b0;
                  state      <= WAIT_TICK;
               end else begin
                  sel        <= sel + 1'b1;
                  sensor_sel <= sel + 1'b1;
                  sensor_req <= 1'b1;
                  toCnt      <= '0;
                  state      <= REQUEST;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm_low  <= '0;
         alarm_high <= '0;
      end else begin
         alarm_low  <= (alarm_low & ~{N_SENSORS{alarm_ack}}) | setLow;
         alarm_high <= (alarm_high & ~{N_SENSORS{alarm_ack}}) | setHigh;
      end
   end

   assign alarm_irq = |{alarm_low, alarm_high};
   assign busy      = state == REQUEST || state == EVALUATE;

endmodule

// File: tb/tb_temp_scan_scheduler.sv
// tb_temp_scan_scheduler: directed scenarios for the scan scheduler
// using a responsive per-sensor model with programmable readings.
module tb_temp_scan_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       alarm_ack;
   logic       sensor_req;
   logic [1:0] sensor_sel;
   logic       sensor_valid;
   logic [7:0] sensor_data;
   logic [3:0] alarm_low;
   logic [3:0] alarm_high;
   logic [3:0] sensor_fault;
   logic       alarm_irq;
   logic       scan_done;
   logic       busy;

   logic [3:0] respond;
   logic [7:0] val [4];
   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;

   logic [7:0] bV0 [6] = '{8'd34, 8'd34, 8'd40, 8'd40, 8'd40, 8'd40};
   logic [7:0] bV1 [6] = '{8'd34, 8'd34, 8'd35, 8'd34, 8'd34, 8'd34};
   logic [7:0] bV3 [6] = '{8'd40, 8'd40, 8'd39, 8'd40, 8'd40, 8'd40};
   logic [3:0] bLow [6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
   logic [3:0] bHigh [6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h9};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign sensor_valid = sensor_req && respond[sensor_sel];
   assign sensor_data  = val[sensor_sel];

   wire [17:0] allOuts = {sensor_req, sensor_sel, alarm_low,
                          alarm_high, alarm_irq, sensor_fault,
                          scan_done, busy};

   temp_scan_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .sensor_req  (sensor_req),
      .sensor_sel  (sensor_sel),
      .sensor_valid(sensor_valid),
      .sensor_data (sensor_data),
      .alarm_low   (alarm_low),
      .alarm_high  (alarm_high),
      .alarm_irq   (alarm_irq),
      .alarm_ack   (alarm_ack),
      .sensor_fault(sensor_fault),
      .scan_done   (scan_done),
      .busy        (busy)
   );

   task automatic waitDone(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = scan_done;
      end
   endtask

   task automatic waitReq(input logic [1:0] s, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = sensor_req && sensor_sel == s;
      end
   endtask

   task automatic countToReq(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!sensor_req && n < 100);
   endtask

   task automatic pulseAck;
      alarm_ack = 1'b1;
      @(negedge clk);
      alarm_ack = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      repeat (3) @(negedge clk);
      nChecks++;
      if (allOuts !== 18'h0) begin
         nFails++;
         $display("FAIL reset_outs: got %h expected 0", allOuts);
      end
      rst_n  = 1'b1;
      enable = 1'b1;
      countToReq(n);
      nChecks++;
      if (n !== 17) begin
         nFails++;
         $display("FAIL first_req_delay: got %0d expected 17", n);
      end
      nChecks++;
      if (busy !== 1'b1 || sensor_sel !== 2'd0) begin
         nFails++;
         $display("FAIL req_busy: got busy=%b sel=%0d expected 1/0",
                  busy, sensor_sel);
      end
      #2 rst_n = 1'b0;
      #1;
      nChecks++;
      if (allOuts !== 18'h0) begin
         nFails++;
         $display("FAIL reset_mid_req: got %h expected 0", allOuts);
      end
      @(negedge clk);
      rst_n = 1'b1;
      countToReq(n);
      nChecks++;
      if (n !== 17) begin
         nFails++;
         $display("FAIL req_after_rst: got %0d expected 17", n);
      end
   endtask

   task automatic test_scan;
      logic [7:0] selLog = '0;
      int k = 0;
      bit done = 1'b0;
      bit ok;
      int t0;
      int period;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (sensor_req) begin
            selLog = {selLog[5:0], sensor_sel};
            k++;
         end
         done = scan_done;
      end
      nChecks++;
      if (!done || k !== 4 || selLog !== 8'h1B) begin
         nFails++;
         $display("FAIL scan_order: got done=%b k=%0d log=%h expected 1/4/1b",
                  done, k, selLog);
      end
      nChecks++;
      if (busy !== 1'b0 ||
          {alarm_low, alarm_high, alarm_irq, sensor_fault} !== 13'h0) begin
         nFails++;
         $display("FAIL scan_clean: got busy=%b al=%h ah=%h f=%h expected 0",
                  busy, alarm_low, alarm_high, sensor_fault);
      end
      t0 = cyc;
      waitDone(ok);
      period = cyc - t0;
      nChecks++;
      if (!ok || period !== 16) begin
         nFails++;
         $display("FAIL scan_period: got %0d ok=%b expected 16",
                  period, ok);
      end
      @(negedge clk);
      nChecks++;
      if (scan_done !== 1'b0) begin
         nFails++;
         $display("FAIL done_pulse: got %b expected 0", scan_done);
      end
   endtask

   task automatic test_low_alarm;
      bit ok;
      bit okAll = 1'b1;
      val[2] = 8'd34;
      waitDone(ok); okAll &= ok;
      waitDone(ok); okAll &= ok;
      nChecks++;
      if (alarm_low !== 4'h0) begin
         nFails++;
         $display("FAIL low_2scans: got %h expected 0", alarm_low);
      end
      waitDone(ok); okAll &= ok;
      nChecks++;
      if (alarm_low !== 4'h4 || alarm_high !== 4'h0 || alarm_irq !== 1'b1) begin
         nFails++;
         $display("FAIL low_alarm: got al=%h ah=%h irq=%b expected 4/0/1",
                  alarm_low, alarm_high, alarm_irq);
      end
      val[2] = 8'd37;
      pulseAck();
      nChecks++;
      if (alarm_low !== 4'h0 || alarm_irq !== 1'b0) begin
         nFails++;
         $display("FAIL low_ack: got al=%h irq=%b expected 0/0",
                  alarm_low, alarm_irq);
      end
      waitDone(ok); okAll &= ok;
      val[2] = 8'd34;
      waitDone(ok); okAll &= ok;
      waitDone(ok); okAll &= ok;
      val[2] = 8'd36;
      waitDone(ok); okAll &= ok;
      val[2] = 8'd37;
      nChecks++;
      if (!okAll || alarm_low !== 4'h0 || alarm_high !== 4'h0) begin
         nFails++;
         $display("FAIL low_34_34_36: got al=%h ah=%h ok=%b expected 0/0/1",
                  alarm_low, alarm_high, okAll);
      end
   endtask

   task automatic test_boundaries;
      bit ok;
      for (int s = 0; s < 6; s++) begin
         val[0] = bV0[s];
         val[1] = bV1[s];
         val[3] = bV3[s];
         waitDone(ok);
         nChecks++;
         if (!ok || alarm_low !== bLow[s] || alarm_high !== bHigh[s]) begin
            nFails++;
            $display("FAIL bound_scan%0d: got al=%h ah=%h expected %h/%h",
                     s, alarm_low, alarm_high, bLow[s], bHigh[s]);
         end
      end
   endtask

   task automatic test_ack;
      bit ok;
      bit okAll = 1'b1;
      val[1] = 8'd37;
      val[3] = 8'd37;
      pulseAck();
      nChecks++;
      if ({alarm_low, alarm_high, alarm_irq} !== 9'h0) begin
         nFails++;
         $display("FAIL ack_clear: got al=%h ah=%h expected 0",
                  alarm_low, alarm_high);
      end
      waitReq(2'd0, ok); okAll &= ok;
      @(negedge clk);
      pulseAck();
      nChecks++;
      if (alarm_high !== 4'h1 || alarm_low !== 4'h0) begin
         nFails++;
         $display("FAIL ack_vs_set: got ah=%h al=%h expected 1/0",
                  alarm_high, alarm_low);
      end
      waitDone(ok); okAll &= ok;
      pulseAck();
      nChecks++;
      if (alarm_high !== 4'h0) begin
         nFails++;
         $display("FAIL ack_persist_clr: got %h expected 0", alarm_high);
      end
      waitDone(ok); okAll &= ok;
      nChecks++;
      if (!okAll || alarm_high !== 4'h1 || alarm_low !== 4'h0) begin
         nFails++;
         $display("FAIL ack_reraise: got ah=%h al=%h ok=%b expected 1/0/1",
                  alarm_high, alarm_low, okAll);
      end
   endtask

   task automatic test_fault;
      bit ok;
      bit okAll = 1'b1;
      bit inReq = 1'b1;
      int n = 1;
      respond[1] = 1'b0;
      waitReq(2'd1, ok); okAll &= ok;
      for (int i = 0; i < 40 && inReq; i++) begin
         @(negedge clk);
         inReq = sensor_req && sensor_sel == 2'd1;
         if (inReq) n++;
      end
      nChecks++;
      if (n !== 15) begin
         nFails++;
         $display("FAIL fault_wait: got %0d cycles expected 15", n);
      end
      nChecks++;
      if (sensor_req !== 1'b1 || sensor_sel !== 2'd2 ||
          sensor_fault !== 4'h2) begin
         nFails++;
         $display("FAIL fault_next: got req=%b sel=%0d f=%h expected 1/2/2",
                  sensor_req, sensor_sel, sensor_fault);
      end
      waitDone(ok); okAll &= ok;
      nChecks++;
      if (sensor_fault !== 4'h2) begin
         nFails++;
         $display("FAIL fault_held: got %h expected 2", sensor_fault);
      end
      respond[1] = 1'b1;
      waitDone(ok); okAll &= ok;
      nChecks++;
      if (!okAll || sensor_fault !== 4'h0) begin
         nFails++;
         $display("FAIL fault_clear: got %h ok=%b expected 0/1",
                  sensor_fault, okAll);
      end
   endtask

   task automatic test_enable;
      bit ok;
      bit seen = 1'b0;
      int n;
      waitReq(2'd0, ok);
      enable = 1'b0;
      @(negedge clk);
      nChecks++;
      if (!ok || sensor_req !== 1'b0 || busy !== 1'b0) begin
         nFails++;
         $display("FAIL disable_req: got req=%b busy=%b ok=%b expected 0/0/1",
                  sensor_req, busy, ok);
      end
      repeat (20) begin
         @(negedge clk);
         seen |= sensor_req | busy;
      end
      nChecks++;
      if (seen !== 1'b0 || alarm_high !== 4'h1) begin
         nFails++;
         $display("FAIL disable_hold: got act=%b ah=%h expected 0/1",
                  seen, alarm_high);
      end
      enable = 1'b1;
      countToReq(n);
      nChecks++;
      if (n !== 17 || sensor_sel !== 2'd0) begin
         nFails++;
         $display("FAIL reenable_req: got %0d sel=%0d expected 17/0",
                  n, sensor_sel);
      end
      waitDone(ok);
      nChecks++;
      if (!ok || alarm_high !== 4'h1 || alarm_low !== 4'h0 ||
          sensor_fault !== 4'h0) begin
         nFails++;
         $display("FAIL reenable_scan: got ah=%h al=%h f=%h expected 1/0/0",
                  alarm_high, alarm_low, sensor_fault);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      enable    = 1'b0;
      alarm_ack = 1'b0;
      respond   = 4'hF;
      for (int i = 0; i < 4; i++) val[i] = 8'd37;
      test_reset();
      test_scan();
      test_low_alarm();
      test_boundaries();
      test_ack();
      test_fault();
      test_enable();
      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule
